// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_queue_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int INS_W_DEF  = 32;
    localparam int LINE_W_DEF = 64;
    localparam logic [ADDR_W_DEF-1:0] START_ADDR_DEF = 64'h8000_0000;

    // Byte-offset widths of a memory line and of one instruction
    localparam int LINE_OFF = $clog2(LINE_W_DEF / 8);
    localparam int INS_OFF  = $clog2(INS_W_DEF / 8);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INS_W_DEF-1:0]  ins;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: redirect input, memory request/response and decode-side output.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INS_W-1:0]  out_ins;
    logic [ADDR_W-1:0] out_snpc;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_pc, out_ins, out_snpc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_ins, out_snpc
    );
endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush and occupancy count; head reads 0 when empty.
module if_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_data = (cnt != '0) ? mem[rd_ptr] : '0;
    assign count    = cnt;
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC owner, multiple outstanding line requests, decoupling queue, redirect squash.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INS_W     = INS_W_DEF,
    parameter int LINE_W    = LINE_W_DEF,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF)
) (
    input  logic           clk,
    input  logic           reset,
    if_fetch_queue_if.master bus
);
    localparam int LOFF  = $clog2(LINE_W / 8);
    localparam int IOFF  = $clog2(INS_W / 8);
    localparam int RATIO = LINE_W / INS_W;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int EW    = ADDR_W + INS_W;
    localparam int QCW   = $clog2(DEPTH + 1);
    localparam int OCW   = $clog2(MAX_OUTST + 1);

    logic [ADDR_W-1:0]           fetch_pc;
    logic [OCW-1:0]              outst, drop_cnt;
    logic [QCW-1:0]              q_cnt;
    logic                        req_fire, resp_keep, pop_fire, q_valid;
    logic [ADDR_W-1:0]           resp_pc, head_pc;
    logic [RATIO-1:0][INS_W-1:0] line;
    logic [SW-1:0]               slot;
    logic [INS_W-1:0]            ins;
    logic [EW-1:0]               q_head;

    // Each issued request reserves a queue slot, so the queue can never overflow on a response
    assign bus.mem_req_valid = reset && !bus.redirect_valid
                             && (int'(outst) < MAX_OUTST)
                             && (int'(q_cnt) + int'(outst) < DEPTH);
    assign req_fire         = bus.mem_req_valid && bus.mem_req_ready;
    assign bus.mem_req_addr = fetch_pc & ~ADDR_W'((1 << LOFF) - 1);

    assign line      = bus.mem_resp_data;
    assign slot      = SW'((resp_pc >> IOFF) & ADDR_W'(RATIO - 1));
    assign ins       = line[slot];
    assign resp_keep = bus.mem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;

    assign q_valid  = (q_cnt != '0);
    assign pop_fire = q_valid && bus.out_ready;

    if_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (bus.mem_resp_valid),
        .pop_data  (resp_pc),
        .count     (outst)
    );

    if_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (resp_keep),
        .push_data ({resp_pc, ins}),
        .pop       (pop_fire),
        .pop_data  (q_head),
        .count     (q_cnt)
    );

    // On redirect every request still in flight (less the one answered now) must be squashed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= START_ADDR;
            drop_cnt <= '0;
        end else begin
            if (bus.redirect_valid)  fetch_pc <= bus.redirect_pc;
            else if (req_fire)       fetch_pc <= fetch_pc + ADDR_W'(INS_W / 8);

            if (bus.redirect_valid)
                drop_cnt <= outst - OCW'(bus.mem_resp_valid);
            else if (bus.mem_resp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - OCW'(1);
        end
    end

    assign head_pc      = q_head[EW-1:INS_W];
    assign bus.out_valid = q_valid;
    assign bus.out_pc    = head_pc;
    assign bus.out_ins   = q_head[INS_W-1:0];
    assign bus.out_snpc  = q_valid ? head_pc + ADDR_W'(INS_W / 8) : '0;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a stream-level reference model and memory responder.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam logic [63:0] START = 64'h8000_0000;
    localparam logic [63:0] RPC   = 64'h8000_0100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    if_fetch_queue_if bus ();
    if_fetch_queue dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { int due; logic [63:0] pc; int ep; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] ins; logic [63:0] snpc; } pop_t;

    req_t pend[$];
    pop_t popped[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, lastdue = 0, epoch = 0, mcnt = 0, n_hs = 0, n_drop = 0;
    int lat_min = 1, lat_max = 1;
    bit rdy_rand = 0, ordy_rand = 0, rdy_fix = 1, ordy_fix = 1;
    logic [63:0] req_pc = START, exp_head = START;
    logic s_req_valid, s_out_valid, s_pop;
    logic [63:0] s_req_addr;

    // Instruction word stored at byte address a
    function automatic logic [31:0] word(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 32'hAAAA_AAAA;
            64'h8000_0004: return 32'hBBBB_BBBB;
            64'h8000_0008: return 32'hCCCC_CCCC;
            64'h8000_000C: return 32'hDDDD_DDDD;
            default:       return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
        endcase
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        logic [63:0] al;
        al = a & ~64'h7;
        return {word(al + 64'd4), word(al)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit redir, input logic [63:0] rpc);
        bit   resp, hs, acc;
        req_t e;
        int   due;
        @(negedge clk);
        resp = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.mem_resp_valid = resp;
        bus.mem_resp_data  = resp ? line_of(pend[0].pc) : 64'h0;
        bus.mem_req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        bus.out_ready      = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_fix;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(mcnt != 0));
        if (mcnt != 0) begin
            chk("out_pc", bus.out_pc, exp_head);
            chk("out_ins", 64'(bus.out_ins), 64'(word(exp_head)));
            chk("out_snpc", bus.out_snpc, exp_head + 64'd4);
        end
        chk("req_valid", 64'(bus.mem_req_valid),
            64'(!redir && pend.size() < 2 && mcnt + pend.size() < 4));
        hs = bus.mem_req_valid && bus.mem_req_ready;
        if (hs) chk("req_addr", bus.mem_req_addr, req_pc & ~64'h7);
        s_req_valid = bus.mem_req_valid;
        s_req_addr  = bus.mem_req_addr;
        s_out_valid = bus.out_valid;
        s_pop       = bus.out_valid && bus.out_ready;
        if (s_pop) popped.push_back('{bus.out_pc, bus.out_ins, bus.out_snpc});
        acc = 0;
        if (resp) begin
            e = pend.pop_front();
            acc = (e.ep == epoch) && !redir;
            if (!acc) n_drop++;
        end
        if (hs) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= lastdue) due = lastdue + 1;
            lastdue = due;
            pend.push_back('{due, req_pc, epoch});
            req_pc += 64'd4;
            n_hs++;
        end
        chk("outstanding_le_max", 64'(pend.size() <= 2), 64'd1);
        if (s_pop) begin
            exp_head += 64'd4;
            mcnt--;
        end
        if (acc) mcnt++;
        if (redir) begin
            epoch++;
            req_pc   = rpc;
            exp_head = rpc;
            mcnt     = 0;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  r;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.out_ready = 0;

        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_ins", 64'(bus.out_ins), 64'd0);
        chk("rst_out_snpc", bus.out_snpc, 64'd0);
        @(negedge clk);
        reset = 1;

        // Plain streaming, 1-cycle memory
        repeat (8) cycle(0, '0);
        chk("t1_pops", 64'(popped.size() >= 3), 64'd1);
        if (popped.size() >= 3) begin
            chk("t1_pc0", popped[0].pc, 64'h8000_0000);
            chk("t1_ins0", 64'(popped[0].ins), 64'hAAAA_AAAA);
            chk("t1_snpc0", popped[0].snpc, 64'h8000_0004);
            chk("t1_pc1", popped[1].pc, 64'h8000_0004);
            chk("t1_ins1", 64'(popped[1].ins), 64'hBBBB_BBBB);
            chk("t1_pc2", popped[2].pc, 64'h8000_0008);
            chk("t1_ins2", 64'(popped[2].ins), 64'hCCCC_CCCC);
        end

        // Decode stalled: fill exactly DEPTH, then one pop frees one slot
        ordy_fix = 0;
        cycle(1, 64'h8000_0200);
        n_hs = 0;
        repeat (12) cycle(0, '0);
        chk("t2_issued", 64'(n_hs), 64'd4);
        chk("t2_req_hold", 64'(s_req_valid), 64'd0);
        ordy_fix = 1;
        cycle(0, '0);
        ordy_fix = 0;
        repeat (6) cycle(0, '0);
        chk("t2_issued_after_pop", 64'(n_hs), 64'd5);

        // Redirect with two requests in flight
        ordy_fix = 1; lat_min = 3; lat_max = 3;
        repeat (6) cycle(0, '0);
        k = 0;
        while (pend.size() != 2 && k < 20) begin
            cycle(0, '0);
            k++;
        end
        chk("t3_two_outst", 64'(pend.size()), 64'd2);
        n_drop = 0;
        cycle(1, RPC);
        popped.delete();
        cycle(0, '0);
        chk("t3_out_valid_after", 64'(s_out_valid), 64'd0);
        repeat (12) cycle(0, '0);
        chk("t3_dropped", 64'(n_drop), 64'd2);
        chk("t3_first_pc", (popped.size() > 0) ? popped[0].pc : 64'hX, RPC);

        // Redirect colliding with a response and a pop
        lat_min = 1; lat_max = 1;
        repeat (6) cycle(0, '0);
        k = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc && mcnt > 0) && k < 20) begin
            cycle(0, '0);
            k++;
        end
        chk("t4_setup", 64'(k < 20), 64'd1);
        cycle(1, RPC);
        chk("t4_no_issue", 64'(s_req_valid), 64'd0);
        chk("t4_pop_done", 64'(s_pop), 64'd1);
        cycle(0, '0);
        chk("t4_req_addr", s_req_addr, RPC);
        chk("t4_out_valid", 64'(s_out_valid), 64'd0);

        // PC wrap at the top of the address space
        popped.delete();
        cycle(1, 64'hFFFF_FFFF_FFFF_FFF8);
        popped.delete();
        repeat (10) cycle(0, '0);
        chk("wrap_pops", 64'(popped.size() >= 3), 64'd1);
        if (popped.size() >= 3) begin
            chk("wrap_pc1", popped[1].pc, 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_snpc1", popped[1].snpc, 64'h0);
            chk("wrap_pc2", popped[2].pc, 64'h0);
        end

        // Random back-pressure, latency and occasional redirects
        rdy_rand = 1; ordy_rand = 1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            cycle(r, 64'h8000_4000 + 64'(4 * $urandom_range(0, 63)));
        end
        rdy_rand = 0; ordy_rand = 0; lat_min = 1; lat_max = 1;
        repeat (6) cycle(0, '0);

        // Asynchronous reset between edges
        #2;
        bus.redirect_valid = 0; bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0; bus.out_ready = 0;
        reset = 0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("arst_out_pc", bus.out_pc, 64'd0);
        chk("arst_out_ins", 64'(bus.out_ins), 64'd0);
        chk("arst_out_snpc", bus.out_snpc, 64'd0);
        pend.delete();
        mcnt = 0; req_pc = START; exp_head = START; lastdue = cyc; epoch++;
        @(negedge clk);
        reset = 1;
        popped.delete();
        repeat (6) cycle(0, '0);
        chk("arst_restart_pc", (popped.size() > 0) ? popped[0].pc : 64'hX, START);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage. It owns the fetch PC and issues line-aligned requests to instruction memory over a valid/ready handshake. It extracts the addressed INS_W-bit instruction from each returned line and buffers {pc, ins} in a DEPTH-entry queue that feeds decode over valid/ready. It replaces single-register IF handling with multiple outstanding requests, a decoupling buffer and clean redirect/flush with in-flight response squashing.

Parameters:
ADDR_W, 64, PC / address width
INS_W, 32, instruction width
LINE_W, 64, memory response width; LINE_W/INS_W is a power of two, >= 1
DEPTH, 4, instruction queue entries (power of two, >= 2)
MAX_OUTST, 2, maximum outstanding memory requests (1..DEPTH)
START_ADDR, 64'h8000_0000, PC after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
redirect_valid  in  1  branch/exception redirect; flushes the stage
redirect_pc  in  ADDR_W  new fetch PC, INS_W/8-aligned
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  fetch_pc with low log2(LINE_W/8) bits cleared
mem_resp_valid  in  1  response valid; in order, one per accepted request, never back-pressured
mem_resp_data  in  LINE_W  returned line
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  ADDR_W  head PC
out_ins  out  INS_W  head instruction
out_snpc  out  ADDR_W  out_pc + INS_W/8

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=START_ADDR; queue empty; outstanding=0; drop_cnt=0; mem_req_valid=0; out_valid=0; out_pc, out_ins and out_snpc read 0.
- Issue: mem_req_valid = !redirect_valid && outstanding<MAX_OUTST && (count+outstanding)<DEPTH. mem_req_valid is combinational from registered state plus redirect_valid.
- Request handshake (valid&&ready): fetch_pc += INS_W/8. The request PC is pushed into an internal in-flight PC FIFO of MAX_OUTST entries. outstanding increments.
- Response: pop the in-flight PC FIFO and decrement outstanding.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {pc, ins} to the queue. ins = mem_resp_data slice selected by pc[log2(LINE_W/8)-1 : log2(INS_W/8)], lowest slice at offset 0.
- Slot reservation: the issue rule reserves a queue slot per request, so a push never meets a full queue.
- Handshake with the same response: request handshake and response in one cycle updates outstanding by net 0.
- Output: out_valid = count!=0. Head pops on out_valid&&out_ready. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Response-to-output latency: a response at cycle t appears at out_valid in cycle t+1 (queue registered, no bypass).
- Redirect at cycle t:
  - fetch_pc<=redirect_pc and the queue is cleared; out_valid=0 at t+1. A pop handshake at t still completes.
  - No request is issued at t.
  - drop_cnt <= outstanding after cycle t's updates, which discards all already-issued responses, including any arriving at t. A response arriving at t is itself discarded.
  - First request with mem_req_addr from redirect_pc can issue at t+1.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed each time, never accumulated twice.
- fetch_pc wraps modulo 2^ADDR_W.
- out_snpc uses ADDR_W-bit wrap arithmetic.
- Reset asserted mid-operation discards everything. Responses to requests issued before reset are the memory side's responsibility, because memory is reset together with this block.

Decomposition:
- Shared package (ysyx_22041071 defines): ADDR_W/INS_W/LINE_W defaults, START_ADDR, the derived shift constants LINE_OFF=log2(LINE_W/8) and INS_OFF=log2(INS_W/8), and the packed queue entry {pc, ins}.
- One sub-module: if_fifo, a parametrised (WIDTH, DEPTH) synchronous FIFO with flush, push, pop and count, under the same active-low asynchronous reset. Instantiate it twice: as the instruction queue and as the in-flight PC FIFO.

Test Plan:
1. Reset release, mem_req_ready=1, one-cycle response latency, data 64'hBBBB_BBBB_AAAA_AAAA then 64'hDDDD_DDDD_CCCC_CCCC → out sequence {8000_0000, AAAA_AAAA, snpc 8000_0004}, {8000_0004, BBBB_BBBB}, {8000_0008, CCCC_CCCC}.
2. out_ready=0 throughout → exactly DEPTH=4 requests issued; mem_req_valid then held 0; raise out_ready for one pop → exactly one new request issued.
3. Two requests outstanding, redirect_valid with redirect_pc=8000_0100 → the next two responses are dropped; the first out_pc is 8000_0100; out_valid=0 the cycle after the redirect.
4. Redirect in the same cycle as a response and a pop → the response is not enqueued, no request is issued that cycle, and mem_req_addr=8000_0100 the next cycle.
5. mem_req_ready toggling randomly with variable response latency ≤3 → PCs are contiguous, and outstanding never exceeds MAX_OUTST.
6. Reset pulsed low mid-stream (asynchronous, off-edge) → all outputs are immediately 0 and fetch restarts at 8000_0000.
